// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Sequential instruction prefetcher with a DEPTH-entry
//               {pc, inst, fault} FIFO feeding the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    output logic            valid_out_idu,
    input  logic            ready_in_idu,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    output logic            fault_out
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_req_addr;
    logic                 r_stale;
    logic                 r_halted;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [XLEN-1:0]      r_pc_mem   [DEPTH];
    logic [XLEN-1:0]      r_inst_mem [DEPTH];
    logic                 r_fault_mem[DEPTH];

    logic                 w_space;
    logic                 w_misaligned;
    logic                 w_pop;
    logic                 w_push;
    logic [XLEN-1:0]      w_push_pc;
    logic [XLEN-1:0]      w_push_inst;
    logic                 w_push_fault;

    assign w_space      = (r_count < c_DEPTH);
    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_pop        = (r_count != '0) && ready_in_idu && !redirect_valid;

    // A misaligned fetch PC never reaches the bus; it becomes a fault entry instead.
    always_comb begin
        w_push       = 1'b0;
        w_push_pc    = r_fetch_pc;
        w_push_inst  = '0;
        w_push_fault = 1'b0;
        if (!redirect_valid) begin
            if (r_state == S_WAIT && rsp_valid) begin
                w_push       = 1'b1;
                w_push_inst  = rsp_err ? '0 : rsp_data;
                w_push_fault = rsp_err;
            end else if (r_state == S_IDLE && !r_halted && w_space && w_misaligned) begin
                w_push       = 1'b1;
                w_push_fault = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= w_push_pc;
            r_inst_mem[r_wr_ptr]  <= w_push_inst;
            r_fault_mem[r_wr_ptr] <= w_push_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_stale    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!redirect_valid && !r_halted && w_space) begin
                        if (w_misaligned) begin
                            r_halted <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_req_addr <= r_fetch_pc;
                            r_stale    <= 1'b0;
                        end
                    end
                end
                // The bus handshake cannot be withdrawn, so a redirect only marks it stale.
                S_REQ: begin
                    if (req_ready) begin
                        r_state <= (r_stale || redirect_valid) ? S_DRAIN : S_WAIT;
                    end else if (redirect_valid) begin
                        r_stale <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        r_state <= S_IDLE;
                        if (!redirect_valid) begin
                            r_fetch_pc <= r_fetch_pc + XLEN'(4);
                            if (rsp_err) r_halted <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rsp_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_halted   <= 1'b0;
            end
        end
    end

    assign req_valid     = (r_state == S_REQ);
    assign req_addr      = r_req_addr;
    assign valid_out_idu = (r_count != '0);
    assign pc_out        = valid_out_idu ? r_pc_mem[r_rd_ptr]    : '0;
    assign inst_out      = valid_out_idu ? r_inst_mem[r_rd_ptr]  : '0;
    assign fault_out     = valid_out_idu ? r_fault_mem[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// Scoreboard bench for ifu_prefetch: a redirect or reset loads the queue with the
// instruction stream expected from that PC; a monitor pops it on every IDU handshake.
module tb_ifu_prefetch;

    localparam logic [31:0] RPC        = 32'h8000_0000;
    localparam int          STREAM_LEN = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        valid_out_idu;
    logic        ready_in_idu = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        fault_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    always #5 clk = ~clk;

    ifu_prefetch #(.XLEN(32), .DEPTH(2), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .valid_out_idu(valid_out_idu), .ready_in_idu(ready_in_idu),
        .pc_out(pc_out), .inst_out(inst_out), .fault_out(fault_out)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    entry_t      sb_q[$];
    logic [31:0] acc_q[$];
    logic        model_halted = 1'b0;
    logic [31:0] err_addr = 32'h1;
    logic        err_rand = 1'b0;
    int          rdy_mode = 0;
    int          lat_max  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic err_at(input logic [31:0] a);
        return (a == err_addr) || (err_rand && (a[6:2] == 5'h13));
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected stream after a restart: sequential words up to and including the first fault.
    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        logic        e;
        p = pc;
        sb_q.delete();
        model_halted = 1'b0;
        if (pc[1:0] != 2'b00) begin
            sb_q.push_back(entry_t'{pc: pc, inst: 32'h0, fault: 1'b1});
        end else begin
            for (int i = 0; i < STREAM_LEN; i++) begin
                e = err_at(p);
                sb_q.push_back(entry_t'{pc: p, inst: (e ? 32'h0 : mem_word(p)), fault: e});
                if (e) break;
                p = p + 32'd4;
            end
        end
    endtask

    // Memory model: acts on negedge for the following posedge.
    logic        m_busy = 1'b0, m_hs = 1'b0, m_pend = 1'b0;
    logic [31:0] m_addr = '0, m_hs_addr = '0, m_pend_addr = '0;
    int          m_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_hs = 1'b0; m_pend = 1'b0;
            rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
            req_ready = (rdy_mode == 0);
        end else begin
            if (m_pend) check("req_hold", {req_valid, req_addr}, {1'b1, m_pend_addr});
            rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
            if (m_hs) begin
                m_busy = 1'b1;
                m_addr = m_hs_addr;
                m_cnt  = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
            end
            if (m_busy) begin
                if (m_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_err   = err_at(m_addr);
                    rsp_data  = mem_word(m_addr);
                    m_busy    = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            case (rdy_mode)
                0:       req_ready = 1'b1;
                1:       req_ready = ($urandom_range(3, 0) != 0);
                default: req_ready = 1'b0;
            endcase
            m_hs        = req_valid && req_ready;
            m_pend      = req_valid && !req_ready;
            m_pend_addr = req_addr;
            if (m_hs) begin
                check("one_outstanding", {m_busy, rsp_valid}, 2'b00);
                check("req_aligned", req_addr[1:0], 2'b00);
                m_hs_addr = req_addr;
                acc_q.push_back(req_addr);
            end
        end
    end

    entry_t mon_e;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (model_halted) check("no_req_halted", req_valid, 1'b0);
            if (!valid_out_idu) check("empty_zero", {pc_out, inst_out, fault_out}, 65'h0);
            if (!redirect_valid && valid_out_idu && ready_in_idu) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got pc %0h expected no output", pc_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    n_pops++;
                    check("idu_head", {pc_out, inst_out, fault_out}, mon_e);
                    if (mon_e.fault) model_halted = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        sb_restart(RPC);
        acc_q.delete();
        step();
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_outputs", {valid_out_idu, pc_out, inst_out, fault_out}, 66'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        sb_restart(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          k;
        int          since;
        int          r;

        // Latency from reset with an always-ready memory and 1-cycle response
        rdy_mode = 0; lat_max = 0; ready_in_idu = 1'b1;
        do_reset();
        check("lat_req_pre", req_valid, 1'b0);
        step(); check("lat_req_rise", req_valid, 1'b1);
        step(); check("lat_rsp", {rsp_valid, valid_out_idu}, 2'b10);
        step(); check("lat_out_rise", valid_out_idu, 1'b1);
        steps(12);
        check("t1_addr2", acc_q[2], 32'h8000_0008);

        // Back-pressure from the decoder limits outstanding words to DEPTH
        ready_in_idu = 1'b0;
        do_reset();
        steps(20);
        check("t2_req_count", acc_q.size(), 2);
        check("t2_req_idle", req_valid, 1'b0);
        ready_in_idu = 1'b1;
        steps(12);
        check("t2_third_addr", acc_q[2], 32'h8000_0008);

        // Held request, redirect during hold
        rdy_mode = 2;
        do_reset();
        steps(5);
        check("t3_held", {req_valid, req_addr}, {1'b1, RPC});
        do_redirect(32'h8000_0100);
        steps(2);
        rdy_mode = 0;
        steps(15);
        check("t3_addr0", acc_q[0], RPC);
        check("t3_addr1", acc_q[1], 32'h8000_0100);

        // Redirect coincident with a response, with one word buffered
        ready_in_idu = 1'b0;
        do_reset();
        steps(3);
        k = 0;
        while (!rsp_valid && k < 20) begin step(); k++; end
        check("t4_rsp_seen", rsp_valid, 1'b1);
        do_redirect(32'h8000_0200);
        check("t4_flushed", valid_out_idu, 1'b0);
        ready_in_idu = 1'b1;
        steps(12);

        // Bus error halts fetch until a redirect
        err_addr = 32'h8000_0004;
        do_reset();
        steps(25);
        check("t5_halt_reqs", acc_q.size(), 2);
        check("t5_halt_idle", {req_valid, valid_out_idu}, 2'b00);
        err_addr = 32'h1;
        do_redirect(RPC);
        steps(12);
        check("t5_resume", acc_q[2], RPC);

        // Misaligned redirect, then address wrap
        do_redirect(32'h8000_0102);
        steps(10);
        acc_q.delete();
        steps(10);
        check("t6_no_req", acc_q.size(), 0);
        do_redirect(32'hFFFF_FFFC);
        steps(12);
        check("t6_wrap0", acc_q[0], 32'hFFFF_FFFC);
        check("t6_wrap1", acc_q[1], 32'h0000_0000);

        // Randomized traffic
        rdy_mode = 1; lat_max = 3; err_rand = 1'b1; err_addr = 32'h1;
        do_reset();
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            ready_in_idu = ($urandom_range(3, 0) != 0);
            r = int'($urandom_range(999, 0));
            if (r < 5) begin
                do_reset();
                since = 0;
            end else if (r < 35 || since > 60) begin
                pc = {20'h80000, 10'($urandom), 2'b00};
                if ($urandom_range(7, 0) == 0) pc[1:0] = 2'($urandom_range(3, 1));
                do_redirect(pc);
                since = 0;
            end else begin
                step();
                since++;
            end
        end
        check("progress", (n_pops > 200), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
